// File: rtl/freq_counter_pkg.sv
// Shared constants, FSM state encoding, result layout and fine-period arithmetic
// for the frequency counter bus master.
package freq_counter_pkg;

  localparam logic [31:0] ADDR_CTRL_DEF  = 32'h8;
  localparam logic [31:0] ADDR_COUNT_DEF = 32'h9;
  localparam logic [31:0] ADDR_PHASE_DEF = 32'hA;

  localparam int CTRL_START = 7;
  localparam int CTRL_DONE  = 6;
  localparam int CTRL_READY = 5;
  localparam int CTRL_CLR   = 0;

  localparam int PHASE_STEPS = 5;

  localparam int COUNT_W = 32;
  localparam int FINE_W  = 35;
  localparam int RES_W   = 1 + COUNT_W + FINE_W;

  typedef enum logic [2:0] {
    IDLE, CLR, ARM, GAP, POLL, RD_CNT, RD_PH, PUSH
  } fsm_state_t;

  typedef struct packed {
    logic               timeout;
    logic [COUNT_W-1:0] count;
    logic [FINE_W-1:0]  fine;
  } result_t;

  // Out-of-range phase steps come from a glitched decoder; treat them as step 0.
  function automatic logic [2:0] phase_step(input logic [2:0] s);
    return (s >= 3'(PHASE_STEPS)) ? 3'd0 : s;
  endfunction

  function automatic logic [FINE_W-1:0] calc_fine(input logic [31:0] count,
                                                  input logic [31:0] phase);
    logic [FINE_W:0] sum;
    sum = {2'b00, count, 2'b00} + {4'b0000, count}
        + {33'd0, phase_step(phase[7:5])} - {33'd0, phase_step(phase[2:0])};
    // count*5 never reaches bit 35, so a set top bit can only mean a negative result
    return sum[FINE_W] ? '0 : sum[FINE_W-1:0];
  endfunction

endpackage

// File: rtl/freq_result_fifo.sv
// Synchronous result FIFO; head entry is presented straight from the storage flops.
module freq_result_fifo
  import freq_counter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  result_t din,
  output logic    full,
  input  logic    pop,
  output logic    valid,
  output result_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  result_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && (!full || do_pop);
  assign full    = (cnt == FULL_CNT);
  assign valid   = (cnt != '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/freq_counter_master.sv
// Wishbone master sequencing the frequency counter slave: clear, arm, poll,
// read count and phase, and queue the combined fine-resolution period.
module freq_counter_master
  import freq_counter_pkg::*;
#(
  parameter logic [31:0] ADDR_CTRL    = ADDR_CTRL_DEF,
  parameter logic [31:0] ADDR_COUNT   = ADDR_COUNT_DEF,
  parameter logic [31:0] ADDR_PHASE   = ADDR_PHASE_DEF,
  parameter int          POLL_GAP     = 16,
  parameter int          MEAS_TIMEOUT = 2**24,
  parameter int          ACK_TIMEOUT  = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        single_i,
  output logic [31:0] addr_o,
  output logic [31:0] dat_o,
  input  logic [31:0] dat_i,
  output logic        we_o,
  output logic [3:0]  sel_o,
  output logic        cyc_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic        err_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [34:0] res_fine_o,
  output logic [31:0] res_count_o,
  output logic        res_timeout_o,
  output logic        busy_o,
  output logic        bus_err_o
);

  localparam int GAP_W  = $clog2(POLL_GAP + 1);
  localparam int MEAS_W = $clog2(MEAS_TIMEOUT + 1);
  localparam int ACKC_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(POLL_GAP - 1);
  localparam logic [MEAS_W-1:0] MEAS_LIM  = MEAS_W'(MEAS_TIMEOUT);
  localparam logic [ACKC_W-1:0] ACK_LIM   = ACKC_W'(ACK_TIMEOUT);
  localparam logic [31:0]       CMD_CLR   = 32'd1 << CTRL_CLR;
  localparam logic [31:0]       CMD_START = 32'd1 << CTRL_START;

  fsm_state_t        state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [MEAS_W-1:0] meas_cnt;
  logic [ACKC_W-1:0] ack_cnt;
  logic              to_pending;
  logic [31:0]       cnt_q;
  result_t           res_q;
  result_t           head;
  logic              fifo_full, push;
  logic [31:0]       bus_addr, bus_dat;
  logic              bus_we;
  logic              strobe_live, accept, abort, meas_expired;

  always_comb begin
    bus_addr = ADDR_CTRL;
    bus_dat  = '0;
    bus_we   = 1'b0;
    case (state)
      CLR:     begin bus_we = 1'b1; bus_dat = CMD_CLR;   end
      ARM:     begin bus_we = 1'b1; bus_dat = CMD_START; end
      RD_CNT:  bus_addr = ADDR_COUNT;
      RD_PH:   bus_addr = ADDR_PHASE;
      default: ;
    endcase
  end

  // The slave holds ack/err level from the previous transaction, so the first
  // strobe cycle (ack_cnt == 0) never qualifies.
  assign strobe_live  = cyc_o && (ack_cnt != '0);
  assign accept       = strobe_live && ack_i && !err_i;
  assign abort        = strobe_live && (err_i || (!ack_i && ack_cnt >= ACK_LIM));
  assign meas_expired = (meas_cnt >= MEAS_LIM);
  assign push         = (state == PUSH) && !fifo_full;
  assign busy_o       = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cyc_o      <= 1'b0;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      sel_o      <= '0;
      addr_o     <= '0;
      dat_o      <= '0;
      ack_cnt    <= '0;
      gap_cnt    <= '0;
      meas_cnt   <= '0;
      to_pending <= 1'b0;
      cnt_q      <= '0;
      res_q      <= '0;
      bus_err_o  <= 1'b0;
    end else begin
      if ((state == GAP || state == POLL) && !meas_expired) meas_cnt <= meas_cnt + 1'b1;
      case (state)
        IDLE: if (run_i || single_i) begin
          state      <= CLR;
          to_pending <= 1'b0;
        end
        GAP: begin
          if (meas_expired) begin
            state      <= CLR;
            to_pending <= 1'b1;
          end else if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= POLL;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        PUSH: if (!fifo_full) state <= run_i ? CLR : IDLE;
        default: begin
          // Bus states: first cycle idle, then hold the strobe until accept/abort.
          if (!cyc_o) begin
            cyc_o   <= 1'b1;
            stb_o   <= 1'b1;
            sel_o   <= 4'hF;
            we_o    <= bus_we;
            addr_o  <= bus_addr;
            dat_o   <= bus_dat;
            ack_cnt <= '0;
          end else if (abort || accept) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            sel_o <= '0;
            we_o  <= 1'b0;
            if (abort) begin
              bus_err_o  <= 1'b1;
              to_pending <= 1'b0;
              state      <= CLR;
            end else begin
              case (state)
                CLR: if (to_pending) begin
                  res_q <= result_t'{timeout: 1'b1, count: '0, fine: '0};
                  state <= PUSH;
                end else begin
                  state <= ARM;
                end
                ARM: begin
                  meas_cnt <= '0;
                  gap_cnt  <= '0;
                  state    <= GAP;
                end
                POLL: begin
                  gap_cnt <= '0;
                  state   <= (dat_i[CTRL_DONE] && !dat_i[CTRL_START]) ? RD_CNT : GAP;
                end
                RD_CNT: begin
                  cnt_q <= dat_i;
                  state <= RD_PH;
                end
                RD_PH: begin
                  res_q <= result_t'{timeout: 1'b0, count: cnt_q, fine: calc_fine(cnt_q, dat_i)};
                  state <= PUSH;
                end
                default: state <= IDLE;
              endcase
            end
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  freq_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .din   (res_q),
    .full  (fifo_full),
    .pop   (res_ready_i),
    .valid (res_valid_o),
    .head  (head)
  );

  assign res_fine_o    = head.fine;
  assign res_count_o   = head.count;
  assign res_timeout_o = head.timeout;

endmodule
